// File: rtl/ili_spi_byte_tx_if.sv
// rtl/ili_spi_byte_tx_if.sv - sequencer-to-transmitter byte request handshake
interface ili_spi_byte_tx_if #(
    parameter int DATA_W = 8
);
    logic              i_send;
    logic [DATA_W-1:0] i_data;
    logic              i_dc;
    logic              i_hold_cs;
    logic              o_busy;
    logic              o_sent;

    modport master (
        output i_send, i_data, i_dc, i_hold_cs,
        input  o_busy, o_sent
    );

    modport slave (
        input  i_send, i_data, i_dc, i_hold_cs,
        output o_busy, o_sent
    );
endinterface

// File: rtl/ili_spi_byte_tx.sv
// rtl/ili_spi_byte_tx.sv - ILI9341 mode-0 SPI byte transmitter with CS hold
module ili_spi_byte_tx #(
    parameter int CLK_DIV = 2,
    parameter int DATA_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    ili_spi_byte_tx_if.slave  bus,
    output logic              o_sclk,
    output logic              o_mosi,
    output logic              o_dc,
    output logic              o_cs_n
);
    localparam int HW = $clog2(CLK_DIV + 1);
    localparam int BW = $clog2(DATA_W);
    localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_TAIL  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]        state;
    logic [DATA_W-1:0] shreg;
    logic [BW-1:0]     bit_cnt;
    logic [HW-1:0]     half_cnt;
    logic              phase;
    logic              dc_reg;
    logic              hold_flag;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            half_cnt  <= '0;
            phase     <= 1'b0;
            dc_reg    <= 1'b1;
            hold_flag <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.i_send) begin
                        shreg     <= bus.i_data;
                        dc_reg    <= bus.i_dc;
                        hold_flag <= bus.i_hold_cs;
                        bit_cnt   <= BIT_LAST;
                        half_cnt  <= '0;
                        phase     <= 1'b0;
                        state     <= ST_SHIFT;
                    end else if (!bus.i_hold_cs) begin
                        hold_flag <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (half_cnt == HALF_LAST) begin
                        half_cnt <= '0;
                        if (!phase) begin
                            phase <= 1'b1;
                        end else begin
                            phase <= 1'b0;
                            // The last bit is not shifted out so MOSI keeps bit 0 through TAIL and IDLE
                            if (bit_cnt == '0) begin
                                state <= ST_TAIL;
                            end else begin
                                shreg   <= {shreg[DATA_W-2:0], 1'b0};
                                bit_cnt <= bit_cnt - BW'(1);
                            end
                        end
                    end else begin
                        half_cnt <= half_cnt + HW'(1);
                    end
                end
                ST_TAIL: begin
                    if (half_cnt == HALF_LAST) begin
                        half_cnt <= '0;
                        state    <= ST_DONE;
                    end else begin
                        half_cnt <= half_cnt + HW'(1);
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_busy = (state != ST_IDLE);
    assign bus.o_sent = (state == ST_DONE);
    assign o_sclk     = (state == ST_SHIFT) && phase;
    assign o_mosi     = shreg[DATA_W-1];
    assign o_dc       = dc_reg;
    assign o_cs_n     = (state == ST_IDLE) ? !hold_flag : 1'b0;
endmodule

// File: tb/tb_ili_spi_byte_tx.sv
// tb/tb_ili_spi_byte_tx.sv - self-checking bench for ili_spi_byte_tx
module tb_ili_spi_byte_tx;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ili_spi_byte_tx_if #(.DATA_W(8)) bus_a ();
    ili_spi_byte_tx_if #(.DATA_W(8)) bus_b ();
    logic sclk_a, mosi_a, dc_a, cs_n_a;
    logic sclk_b, mosi_b, dc_b, cs_n_b;

    ili_spi_byte_tx #(.CLK_DIV(2), .DATA_W(8)) dut_a (
        .clk(clk), .rst(rst_n), .bus(bus_a.slave),
        .o_sclk(sclk_a), .o_mosi(mosi_a), .o_dc(dc_a), .o_cs_n(cs_n_a)
    );
    ili_spi_byte_tx #(.CLK_DIV(1), .DATA_W(8)) dut_b (
        .clk(clk), .rst(rst_n), .bus(bus_b.slave),
        .o_sclk(sclk_b), .o_mosi(mosi_b), .o_dc(dc_b), .o_cs_n(cs_n_b)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         sel;
        logic [7:0] data;
        logic       dc;
        logic       hold;
        bit         keep;
        logic [7:0] exp_bits;
        int         exp_busy;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input int sel, input logic send, input logic [7:0] data,
                         input logic dc, input logic hold);
        if (sel == 0) begin
            bus_a.i_send = send; bus_a.i_data = data; bus_a.i_dc = dc; bus_a.i_hold_cs = hold;
        end else begin
            bus_b.i_send = send; bus_b.i_data = data; bus_b.i_dc = dc; bus_b.i_hold_cs = hold;
        end
    endtask

    task automatic sample(input int sel, output logic sclk, output logic mosi, output logic dc,
                          output logic cs_n, output logic busy, output logic sent);
        if (sel == 0) begin
            sclk = sclk_a; mosi = mosi_a; dc = dc_a; cs_n = cs_n_a; busy = bus_a.o_busy; sent = bus_a.o_sent;
        end else begin
            sclk = sclk_b; mosi = mosi_b; dc = dc_b; cs_n = cs_n_b; busy = bus_b.o_busy; sent = bus_b.o_sent;
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the IDLE cycle after DONE.
    task automatic xfer(input int sel, input logic [7:0] data, input logic dc, input logic hold,
                        input bit keep, input logic [7:0] exp_bits, input int exp_busy,
                        input string tag);
        int d = (sel == 0) ? 2 : 1;
        int busy_n = 0, rises = 0, sent_at = 0, first_rise = 0, last_rise = 0;
        int dc_bad = 0, cs_bad = 0;
        logic [7:0] bits = '0;
        logic prev = 1'b0;
        logic s_sclk, s_mosi, s_dc, s_cs_n, s_busy, s_sent;
        drive(sel, 1'b1, data, dc, hold);
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            sample(sel, s_sclk, s_mosi, s_dc, s_cs_n, s_busy, s_sent);
            if (cyc == 1) chk({tag, " start"}, int'(s_busy), 1);
            if (keep) drive(sel, 1'b1, 8'($urandom), 1'($urandom), hold);
            else if (cyc == 1) drive(sel, 1'b0, ~data, ~dc, hold);
            if (s_busy) busy_n++;
            if (s_busy && s_dc !== dc) dc_bad++;
            if (s_busy && s_cs_n !== 1'b0) cs_bad++;
            if (s_sclk && !prev) begin
                rises++;
                if (rises == 1) first_rise = cyc;
                last_rise = cyc;
                if (rises <= 8) bits[8 - rises] = s_mosi;
            end
            prev = s_sclk;
            if (s_sent) begin
                sent_at = cyc;
                break;
            end
        end
        chk({tag, " busy_cycles"}, busy_n, exp_busy);
        chk({tag, " sent_cycle"}, sent_at, exp_busy);
        chk({tag, " sclk_rises"}, rises, 8);
        chk({tag, " mosi_bits"}, int'(bits), int'(exp_bits));
        chk({tag, " first_rise"}, first_rise, d + 1);
        chk({tag, " last_rise"}, last_rise, d + 1 + 14 * d);
        chk({tag, " dc_bad"}, dc_bad, 0);
        chk({tag, " cs_bad"}, cs_bad, 0);
        @(negedge clk);
        sample(sel, s_sclk, s_mosi, s_dc, s_cs_n, s_busy, s_sent);
        chk({tag, " idle_busy"}, int'(s_busy), 0);
        chk({tag, " idle_sent"}, int'(s_sent), 0);
        chk({tag, " idle_sclk"}, int'(s_sclk), 0);
        chk({tag, " idle_cs_n"}, int'(s_cs_n), int'(!hold));
        chk({tag, " idle_dc"}, int'(s_dc), int'(dc));
        chk({tag, " idle_mosi"}, int'(s_mosi), int'(data[0]));
    endtask

    vec_t vecs[6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rises;
        logic prev;
        logic s_sclk, s_mosi, s_dc, s_cs_n, s_busy, s_sent;
        vecs[0] = '{0, 8'h2A, 1'b0, 1'b0, 1'b0, 8'h2A, 35};
        vecs[1] = '{0, 8'h36, 1'b0, 1'b1, 1'b0, 8'h36, 35};
        vecs[2] = '{0, 8'h48, 1'b1, 1'b0, 1'b0, 8'h48, 35};
        vecs[3] = '{0, 8'hFF, 1'b1, 1'b0, 1'b1, 8'hFF, 35};
        vecs[4] = '{0, 8'h5C, 1'b0, 1'b0, 1'b0, 8'h5C, 35};
        vecs[5] = '{1, 8'h80, 1'b1, 1'b0, 1'b0, 8'h80, 18};

        drive(0, 1'b1, 8'hFF, 1'b0, 1'b1);
        drive(1, 1'b1, 8'hFF, 1'b0, 1'b1);
        rises = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            for (int s = 0; s < 2; s++) begin
                sample(s, s_sclk, s_mosi, s_dc, s_cs_n, s_busy, s_sent);
                chk("reset cs_n", int'(s_cs_n), 1);
                chk("reset dc", int'(s_dc), 1);
                chk("reset busy", int'(s_busy), 0);
                chk("reset sent", int'(s_sent), 0);
                if (s_sclk) rises++;
            end
        end
        chk("reset sclk_edges", rises, 0);
        drive(0, 1'b0, 8'h00, 1'b0, 1'b0);
        drive(1, 1'b0, 8'h00, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 6; v++)
            xfer(vecs[v].sel, vecs[v].data, vecs[v].dc, vecs[v].hold, vecs[v].keep,
                 vecs[v].exp_bits, vecs[v].exp_busy, $sformatf("vec%0d", v));

        // Abort a frame after the third SCLK rise.
        drive(0, 1'b1, 8'hA5, 1'b0, 1'b0);
        rises = 0;
        prev = 1'b0;
        for (int cyc = 0; cyc < 100 && rises < 3; cyc++) begin
            @(negedge clk);
            drive(0, 1'b0, 8'hA5, 1'b0, 1'b0);
            if (sclk_a && !prev) rises++;
            prev = sclk_a;
        end
        chk("abort rises_before", rises, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("abort sclk", int'(sclk_a), 0);
        chk("abort mosi", int'(mosi_a), 0);
        chk("abort dc", int'(dc_a), 1);
        chk("abort cs_n", int'(cs_n_a), 1);
        chk("abort busy", int'(bus_a.o_busy), 0);
        chk("abort sent", int'(bus_a.o_sent), 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("abort held_sent", int'(bus_a.o_sent), 0);
            chk("abort held_sclk", int'(sclk_a), 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort post_sent", int'(bus_a.o_sent), 0);
        xfer(0, 8'h01, 1'b1, 1'b0, 1'b0, 8'h01, 35, "after_abort");

        for (int r = 0; r < 8; r++) begin
            int sel = int'($urandom_range(0, 1));
            logic [7:0] data = 8'($urandom);
            logic dc = 1'($urandom);
            logic hold = 1'($urandom);
            int d = (sel == 0) ? 2 : 1;
            xfer(sel, data, dc, hold, 1'b0, data, 16 * d + d + 1, $sformatf("rnd%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ili_spi_byte_tx.md
Name: ili_spi_byte_tx

Overview:
- Byte-level SPI transmitter for the ILI9341 panel interface.
- Sits directly downstream of the init and command sequencers. It accepts one byte per request, together with its D/C flag.
- Serialises the byte MSB-first in SPI mode 0 and drives the panel pins SCLK, MOSI, D/C and CS_n.
- When the byte is on the wire it returns a one-cycle "sent" pulse. The sequencer uses this pulse to advance its command index.

Parameters:
- CLK_DIV, 2: number of clk cycles per SCLK half-period. Legal values are >= 1. The half-period counter is $clog2(CLK_DIV+1) bits wide.
- DATA_W, 8: bits per transfer. This is fixed at 8 for the ILI9341. Other values need not be supported.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- i_send  in  1  transfer request, sampled only in IDLE.
- i_data  in  DATA_W  byte to send, captured on the accepting edge.
- i_dc  in  1  D/C level for this byte: 0 = command, 1 = data. Captured with i_data.
- i_hold_cs  in  1  keep CS asserted after this byte. Captured with i_data. Also sampled in IDLE to release CS.
- o_busy  out  1  high from the cycle after acceptance through the DONE cycle.
- o_sent  out  1  one-cycle pulse when the transfer completes.
- o_sclk  out  1  SPI clock, idle low.
- o_mosi  out  1  serial data, MSB first.
- o_dc  out  1  panel D/C pin.
- o_cs_n  out  1  panel chip select, active low.

Behaviour:
- Reset (rst low, asynchronous, any state, including mid-frame): state = IDLE, shift register = 0, counters = 0, hold flag = 0.
  - Outputs at reset: o_sclk=0, o_mosi=0, o_dc=1, o_cs_n=1, o_sent=0, o_busy=0.
  - No o_sent pulse is generated for an aborted byte.
- States: IDLE, SHIFT, TAIL, DONE.
- IDLE:
  - o_sclk=0, o_busy=0, o_sent=0.
  - o_cs_n = !hold_flag.
  - o_dc and o_mosi hold their last values.
  - If i_send=1 on a clk edge:
    - capture i_data into the shift register;
    - capture i_dc into the dc register;
    - capture i_hold_cs into hold_flag;
    - go to SHIFT with bit counter = 7 and half counter = 0.
  - Else if i_hold_cs=0: clear hold_flag, so CS_n rises on the next cycle.
- SHIFT:
  - o_busy=1, o_cs_n=0, o_dc = captured dc, o_mosi = shift register MSB.
  - Each bit occupies 2*CLK_DIV cycles: CLK_DIV cycles with o_sclk=0, then CLK_DIV cycles with o_sclk=1.
  - The rising SCLK edge is the panel's sample point. MOSI is stable for the whole high phase.
  - At the end of the high phase:
    - o_sclk returns to 0;
    - the shift register shifts left by one;
    - the bit counter decrements.
  - After the bit-0 high phase, go to TAIL.
- TAIL:
  - Lasts CLK_DIV cycles.
  - o_sclk=0, CS_n stays low, MOSI holds bit 0.
  - Guarantees CS/DC hold time after the last edge.
- DONE:
  - Lasts exactly 1 cycle.
  - o_sent=1, o_busy=1, CS_n still low.
  - Next state is IDLE.
- Latency: from the accepting edge, o_busy is high for 16*CLK_DIV + CLK_DIV + 1 cycles. o_sent is in the last of these cycles.
  - With CLK_DIV=2: o_busy is high for 35 cycles.
  - The first SCLK rise is CLK_DIV cycles after o_busy rises.
- i_send while busy: ignored, with no queueing. The upstream block must wait for o_sent.
- Back-to-back transfers: i_send may be high in the cycle immediately after DONE, which is an IDLE cycle.
  - If hold_flag=1, CS_n stays low continuously across both bytes.
  - If hold_flag=0, CS_n goes high for at least that one IDLE cycle.
- i_dc change mid-frame: no effect. Only the captured value drives o_dc.
- Exactly 8 SCLK rising edges per accepted byte, never more and never fewer.

Test Plan:
- Reset check: hold rst low for 3 cycles with i_send=1 -> o_cs_n=1, o_sclk=0, o_dc=1, o_busy=0, o_sent=0. No edges appear on o_sclk.
- Single command byte: CLK_DIV=2, send i_data=8'h2A, i_dc=0, i_hold_cs=0 -> the following must all hold:
  - o_cs_n low for 35 cycles;
  - exactly 8 SCLK rises;
  - sampled MOSI = 0,0,1,0,1,0,1,0;
  - o_dc=0 throughout;
  - o_sent pulses once, in busy cycle 35;
  - o_cs_n high in the following cycle.
- Command then data with hold: send 8'h36 (dc=0, hold=1), then 8'h48 (dc=1, hold=0) in the cycle after o_sent -> the following must all hold:
  - CS_n never deasserts between the bytes;
  - o_dc switches 0 -> 1 at the second byte;
  - 16 SCLK rises in total;
  - two o_sent pulses;
  - CS_n rises after the second DONE.
- Busy rejection: assert i_send continuously with changing i_data during a transfer of 8'hFF -> all 8 sampled bits are 1. The second byte starts only in the IDLE cycle after o_sent.
- Reset mid-frame: drop rst after the 3rd SCLK rise -> the following must all hold:
  - outputs return to their reset values asynchronously;
  - no o_sent pulse;
  - the next request, 8'h01, transmits a full, correct 8 bits.
- CLK_DIV=1 corner: send 8'h80 -> o_busy high for 18 cycles, SCLK toggles every cycle, the first sampled bit is 1 and the rest are 0.
